// File: rtl/mash_pkg.sv
// ============================================================================
// Module   : mash_pkg
// Purpose  : Shared constants and helpers for the MASH delta-sigma modulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mash_pkg;

    localparam int          MASH_MAX_STAGES = 4;
    localparam logic [14:0] LFSR_SEED       = 15'h0001;

    // Requested order is encoded as order-1; anything beyond the built stages clamps.
    function automatic logic [2:0] clamp_order(input logic [1:0] i_req, input int n_stages);
        logic [2:0] w_req;
        w_req = {1'b0, i_req} + 3'd1;
        if (int'(w_req) > n_stages) begin
            return 3'(n_stages);
        end
        return w_req;
    endfunction

    function automatic int out_width(input int n_stages);
        return n_stages + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mash_acc_stage.sv
// ============================================================================
// Module   : mash_acc_stage
// Purpose  : One W-bit MASH accumulator with combinational sum/carry output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mash_acc_stage #(
    parameter int P_DATA_WIDTH = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic                    i_active,
    input  logic                    i_load,
    input  logic                    i_cin,
    input  logic [P_DATA_WIDTH-1:0] i_addend,
    input  logic [P_DATA_WIDTH-1:0] i_load_val,
    output logic [P_DATA_WIDTH-1:0] o_sum,
    output logic                    o_carry
);

    logic [P_DATA_WIDTH-1:0] r_acc;
    logic [P_DATA_WIDTH:0]   w_s;

    assign w_s     = {1'b0, r_acc} + {1'b0, i_addend} + {{P_DATA_WIDTH{1'b0}}, i_cin};
    // An inactive stage must look like an empty one to the cancellation network.
    assign o_sum   = i_active ? w_s[P_DATA_WIDTH-1:0] : '0;
    assign o_carry = i_active & w_s[P_DATA_WIDTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_load) begin
            r_acc <= i_load_val;
        end else if (i_en) begin
            r_acc <= i_active ? w_s[P_DATA_WIDTH-1:0] : '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mash_ddsm.sv
// ============================================================================
// Module   : mash_ddsm
// Purpose  : Runtime-order MASH delta-sigma modulator (1..P_NUM_STAGES).
//            Optional LSB dither enabled by defining MASH_DITHER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mash_ddsm
    import mash_pkg::*;
#(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_NUM_STAGES = 3
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_en,
    input  logic                                  i_load,
    input  logic [P_DATA_WIDTH-1:0]               i_seed,
    input  logic [1:0]                            i_order,
    input  logic [P_DATA_WIDTH-1:0]               i_data,
    output logic [out_width(P_NUM_STAGES)-1:0]    o_out,
    output logic                                  o_valid
);

    localparam int W  = P_DATA_WIDTH;
    localparam int N  = P_NUM_STAGES;
    localparam int OW = out_width(P_NUM_STAGES);

    // Binomial weights of the delayed carries for each stage (1-3z^-1+3z^-2-z^-3 ...).
    localparam int C_D1 [MASH_MAX_STAGES] = '{0, 1, 2, 3};
    localparam int C_D2 [MASH_MAX_STAGES] = '{0, 0, 1, 3};
    localparam int C_D3 [MASH_MAX_STAGES] = '{0, 0, 0, 1};

    logic [2:0]    r_order;
    logic [N-1:0]  w_c;
    logic [N-1:0]  w_active;
    logic [N-1:0]  r_cd1, r_cd2, r_cd3;
    logic [W-1:0]  w_sum [N];
    logic          w_cin;
    logic [OW-1:0] w_y;
    logic [OW-1:0] r_out;
    logic          r_valid;
    logic          w_unused_tail;

`ifdef MASH_DITHER_EN
    logic [14:0] r_lfsr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_load) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_en) begin
            r_lfsr <= {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};
        end
    end

    assign w_cin = r_lfsr[0];
`else
    assign w_cin = 1'b0;
`endif

    for (genvar k = 0; k < N; k++) begin : g_stage
        logic [W-1:0] w_addend;
        logic         w_stage_cin;
        logic [W-1:0] w_load_val;

        if (k == 0) begin : g_head
            assign w_addend    = i_data;
            assign w_stage_cin = w_cin;
            assign w_load_val  = i_seed;
        end else begin : g_tail
            assign w_addend    = w_sum[k-1];
            assign w_stage_cin = 1'b0;
            assign w_load_val  = '0;
        end

        assign w_active[k] = (3'(k) < r_order);

        mash_acc_stage #(
            .P_DATA_WIDTH (W)
        ) u_stage (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_en       (i_en),
            .i_active   (w_active[k]),
            .i_load     (i_load),
            .i_cin      (w_stage_cin),
            .i_addend   (w_addend),
            .i_load_val (w_load_val),
            .o_sum      (w_sum[k]),
            .o_carry    (w_c[k])
        );
    end

    // The last stage's residue has no consumer.
    assign w_unused_tail = ^w_sum[N-1];

    // Modular OW-bit arithmetic: intermediate wrap is harmless, the final sum always fits.
    always_comb begin
        w_y = '0;
        for (int k = 0; k < N; k++) begin
            w_y = w_y + OW'(w_c[k])
                      - OW'(r_cd1[k]) * OW'(C_D1[k])
                      + OW'(r_cd2[k]) * OW'(C_D2[k])
                      - OW'(r_cd3[k]) * OW'(C_D3[k]);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_order <= 3'(N);
            r_cd1   <= '0;
            r_cd2   <= '0;
            r_cd3   <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_order <= clamp_order(i_order, N);
            r_cd1   <= '0;
            r_cd2   <= '0;
            r_cd3   <= '0;
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_cd1   <= w_c;
            r_cd2   <= r_cd1;
            r_cd3   <= r_cd2;
            r_out   <= w_y;
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign o_out   = r_out;
    assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_mash_ddsm.sv
// ============================================================================
// Module   : tb_mash_ddsm
// Purpose  : Directed self-checking bench for mash_ddsm (default, undithered build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mash_ddsm;

    localparam int W = 8;
    localparam int N = 3;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_en;
    logic         i_load;
    logic [W-1:0] i_seed;
    logic [1:0]   i_order;
    logic [W-1:0] i_data;
    logic [N:0]   o_out;
    logic         o_valid;

    int n_chk = 0;
    int n_bad = 0;
    int last_y;

    int m_acc [4];
    int m_d1  [4];
    int m_d2  [4];
    int m_d3  [4];
    int m_ord;

    always #5 i_clk = ~i_clk;

    mash_ddsm #(
        .P_DATA_WIDTH (W),
        .P_NUM_STAGES (N)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_en),
        .i_load  (i_load),
        .i_seed  (i_seed),
        .i_order (i_order),
        .i_data  (i_data),
        .o_out   (o_out),
        .o_valid (o_valid)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sout();
        return int'($signed(o_out));
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic mdl_clear(input int seed, input int ord);
        m_ord = ord;
        for (int k = 0; k < 4; k++) begin
            m_acc[k] = (k == 0) ? seed : 0;
            m_d1[k]  = 0;
            m_d2[k]  = 0;
            m_d3[k]  = 0;
        end
    endtask

    // Reference MASH written straight from the cancellation equation.
    task automatic mdl_step(input int data, output int y);
        int c [4];
        int add;
        int s;
        add = data;
        for (int k = 0; k < 4; k++) begin
            c[k] = 0;
            if (k < m_ord) begin
                s        = m_acc[k] + add;
                c[k]     = s / 256;
                m_acc[k] = s % 256;
                add      = s % 256;
            end
        end
        y = c[0] + (c[1] - m_d1[1]) + (c[2] - 2*m_d1[2] + m_d2[2])
                 + (c[3] - 3*m_d1[3] + 3*m_d2[3] - m_d3[3]);
        for (int k = 0; k < 4; k++) begin
            m_d3[k] = m_d2[k];
            m_d2[k] = m_d1[k];
            m_d1[k] = c[k];
        end
    endtask

    task automatic run_load(input int seed, input int ord_req);
        i_load  = 1'b1;
        i_en    = 1'b1;
        i_seed  = W'(seed);
        i_order = 2'(ord_req);
        tick();
        chk("load_novalid", int'(o_valid), 0);
        chk("load_hold", sout(), last_y);
        i_load = 1'b0;
        mdl_clear(seed, (ord_req + 1 > N) ? N : ord_req + 1);
    endtask

    initial begin
        int seq3 [4];
        int y;
        int sum;
        int bad_rng;
        int nz;
        seq3 = '{0, 2, -1, 1};

        i_rst_n = 1'b0;
        i_en    = 1'b1;
        i_load  = 1'b0;
        i_seed  = '0;
        i_order = 2'd0;
        i_data  = 8'd128;
        last_y  = 0;

        repeat (3) tick();
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_out", sout(), 0);

        // Out of reset the modulator runs at full order.
        @(negedge i_clk);
        i_rst_n = 1'b1;
        mdl_clear(0, N);
        tick();
        chk("rst_ord_s0", sout(), 0);
        tick();
        chk("rst_ord_s1", sout(), 2);
        chk("rst_ord_valid", int'(o_valid), 1);

        #2;
        i_rst_n = 1'b0;
        #1;
        chk("async_out", sout(), 0);
        chk("async_valid", int'(o_valid), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        last_y  = 0;

        // Order 1, input 64/256 -> 0,0,0,1 repeating.
        run_load(0, 0);
        i_data = 8'd64;
        for (int i = 0; i < 8; i++) begin
            tick();
            mdl_step(64, y);
            chk("ord1_seq", sout(), (i % 4 == 3) ? 1 : 0);
            last_y = y;
        end

        // Order 3, input 128: mean 1/2, bounded range.
        run_load(0, 2);
        i_data  = 8'd128;
        sum     = 0;
        bad_rng = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            mdl_step(128, y);
            if (i < 4) chk("ord3_seq", sout(), seq3[i]);
            chk("ord3_mdl", sout(), y);
            sum += sout();
            if (sout() < -3 || sout() > 4) bad_rng++;
            last_y = y;
        end
        chk("ord3_sum", sum, 128);
        chk("ord3_range", bad_rng, 0);

        run_load(0, 2);
        i_data = 8'd0;
        nz     = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (sout() != 0) nz++;
        end
        chk("ord3_zero", nz, 0);
        last_y = 0;

        // Requested order 4 on a 3-stage build clamps to 3.
        run_load(0, 3);
        i_data = 8'd128;
        for (int i = 0; i < 4; i++) begin
            tick();
            mdl_step(128, y);
            chk("clamp_seq", sout(), seq3[i]);
            last_y = y;
        end

        // Random enable gaps; an i_order change without a load must be ignored.
        run_load(0, 2);
        i_data = 8'd37;
        for (int i = 0; i < 150; i++) begin
            i_en = 1'($urandom_range(0, 1));
            if (i == 75) i_order = 2'd0;
            tick();
            if (i_en) begin
                mdl_step(37, y);
                chk("gap_out", sout(), y);
                chk("gap_valid", int'(o_valid), 1);
                last_y = y;
            end else begin
                chk("gap_hold", sout(), last_y);
                chk("gap_novalid", int'(o_valid), 0);
            end
        end

        // Load wins over enable; seed 240 + 16 overflows on the next sample.
        i_data = 8'd16;
        run_load(240, 0);
        tick();
        chk("seed_carry", sout(), 1);
        chk("seed_valid", int'(o_valid), 1);
        tick();
        chk("seed_next", sout(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
